regfile_wb_unit: RTL and testbench
==================================

Name: regfile_wb_unit

Overview:
- Write-side producer for the register file: collects writeback results from the ALU and the load unit and drives the register file's single write port (write enable, write address, write data).
- Load results are buffered in a small FIFO. ALU results have priority, with a starvation guard for loads.
- Provides a write-through bypass for the value committed at the next edge, because the register file has no internal bypass.
- Provides a pending-load mask for the issue stage.

Parameters:
- DATA_WIDTH, 32, width of register data.
- ADDR_WIDTH, 5, register address width.
- FIFO_DEPTH, 4, load-result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 8, maximum consecutive cycles the FIFO head may be blocked by the ALU.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- alu_valid_i  in  1  ALU result valid.
- alu_ready_o  out  1  ALU result accepted this cycle.
- alu_addr_i  in  ADDR_WIDTH  ALU destination register.
- alu_data_i  in  DATA_WIDTH  ALU result.
- ld_valid_i  in  1  load result valid.
- ld_ready_o  out  1  FIFO can accept a load result.
- ld_addr_i  in  ADDR_WIDTH  load destination register.
- ld_data_i  in  DATA_WIDTH  load data.
- wr_enable_o  out  1  register file write enable.
- wr_addr_o  out  ADDR_WIDTH  register file write address.
- wr_data_o  out  DATA_WIDTH  register file write data.
- byp_addr1_i / byp_addr2_i  in  ADDR_WIDTH  read-port addresses to check for bypass.
- byp_hit1_o / byp_hit2_o  out  1  bypass valid for the matching port.
- byp_data1_o / byp_data2_o  out  DATA_WIDTH  bypass data.
- ld_pending_o  out  2**ADDR_WIDTH  bit r set when a load to xr is in the FIFO or the output stage.
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, any cycle, including mid-drain):
  - wr_enable_o=0, wr_addr_o=0, wr_data_o=0.
  - FIFO emptied, fifo_count_o=0, starvation counter=0, state=NORMAL.
  - ld_pending_o=0, byp_hit*=0, byp_data*=0.
  - ld_ready_o=1 and alu_ready_o=1 once reset is deasserted.
- Output stage: a single register. Whatever is selected in cycle N appears on wr_* after the edge ending cycle N. The register file commits it at the following edge.
  - ALU latency: 1 cycle.
  - Load latency through an empty FIFO: 2 cycles (enqueue, pop, present).
- Load acceptance:
  - ld_ready_o = (fifo_count_o < FIFO_DEPTH), based on registered count only; no same-cycle pass-through when full.
  - A load is accepted on ld_valid_i && ld_ready_o.
  - Push and pop in the same cycle are allowed; count is unchanged.
- x0 handling: requests with address 0 are accepted by the handshake and then discarded. They are never enqueued, never produce wr_enable_o=1, and never set a pending bit.
- State machine with states NORMAL and FORCE_DRAIN:
  - NORMAL: alu_ready_o=1.
    - If alu_valid_i is high with a non-zero address, the ALU is selected.
    - Otherwise, if the FIFO is non-empty, the head is popped and selected.
    - If nothing is selected, wr_enable_o=0 next cycle.
  - Starvation counter: increments each cycle the FIFO is non-empty and the head is not popped; clears on any pop.
  - NORMAL→FORCE_DRAIN when the counter reaches STARVE_LIMIT.
  - FORCE_DRAIN: alu_ready_o=0, the head is popped and selected, counter cleared, then →NORMAL. This lasts exactly 1 cycle.
- Bypass (combinational):
  - byp_hitK_o=1 when wr_enable_o=1, wr_addr_o==byp_addrK_i, and byp_addrK_i≠0.
  - byp_dataK_o=wr_data_o when hit, else 0.
  - FIFO entries are not bypassed; ld_pending_o covers them.
- ld_pending_o: OR of one-hot decode over valid FIFO entries plus the output stage when it holds a load. Bit 0 is always 0.
- FIFO pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by the count.
- Write ordering among entries targeting the same register is the issue stage's responsibility. This unit preserves FIFO order among loads only.

Test Plan:
- Reset, then alu_valid_i=1, addr=5, data=0xAAAAAAAA for 1 cycle -> next cycle wr_enable_o=1, wr_addr_o=5, wr_data_o=0xAAAAAAAA; byp_addr1_i=5 gives byp_hit1_o=1 with 0xAAAAAAAA; following cycle wr_enable_o=0.
- ALU idle, 4 loads back-to-back to x1..x4 with data 0xA0000001..4 -> all accepted; writes appear in order x1..x4, the first 2 cycles after its push; ld_pending_o bits 1-4 clear one by one.
- ALU held valid (addr 7), 5 loads offered -> ld_ready_o=0 on the 5th offer (count=4); after 8 blocked cycles alu_ready_o=0 for exactly 1 cycle and x1 is written; the stalled ALU request is written the cycle after.
- alu addr=0 with data 0xDEADBEEF, and a load to x0 -> both accepted; wr_enable_o never asserted; fifo_count_o stays 0; ld_pending_o[0]=0.
- Simultaneous push and pop at count=2 -> count stays 2; data order is preserved across pointer wrap after 10 pushes.
- Assert rst_i mid-operation with count=3 and wr_enable_o=1 -> outputs zero immediately (asynchronous); after release, count=0, ld_ready_o=1, and no stale write appears.

Source files
------------

// File: rtl/regfile_wb_unit.sv
// regfile_wb_unit: writeback arbiter for the register file's single write port.
// ALU results take priority. Load results are buffered in a small FIFO.
// A starvation counter forces a one-cycle load drain when the ALU keeps the
// FIFO head blocked. The unit also provides a write-through bypass of the
// value on the write port and a pending-load mask for the issue stage.
module regfile_wb_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          alu_valid_i,
  output logic                          alu_ready_o,
  input  logic [ADDR_WIDTH-1:0]         alu_addr_i,
  input  logic [DATA_WIDTH-1:0]         alu_data_i,
  input  logic                          ld_valid_i,
  output logic                          ld_ready_o,
  input  logic [ADDR_WIDTH-1:0]         ld_addr_i,
  input  logic [DATA_WIDTH-1:0]         ld_data_i,
  output logic                          wr_enable_o,
  output logic [ADDR_WIDTH-1:0]         wr_addr_o,
  output logic [DATA_WIDTH-1:0]         wr_data_o,
  input  logic [ADDR_WIDTH-1:0]         byp_addr1_i,
  input  logic [ADDR_WIDTH-1:0]         byp_addr2_i,
  output logic                          byp_hit1_o,
  output logic                          byp_hit2_o,
  output logic [DATA_WIDTH-1:0]         byp_data1_o,
  output logic [DATA_WIDTH-1:0]         byp_data2_o,
  output logic [(2**ADDR_WIDTH)-1:0]    ld_pending_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int NREG  = 2**ADDR_WIDTH;

  typedef enum logic {
    ST_NORMAL      = 1'b0,
    ST_FORCE_DRAIN = 1'b1
  } state_t;

  // Registered state
  state_t                r_state;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic [STV_W-1:0]      r_starve;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_out_ld;
  logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];

  // Combinational signals
  state_t                w_state_nxt;
  logic                  w_fifo_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_sel_alu;
  logic                  w_alu_ready;
  logic [STV_W-1:0]      w_starve_nxt;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [PTR_W-1:0]      w_idx;
  logic [NREG-1:0]       w_pending;

  assign w_fifo_empty = (r_count == {CNT_W{1'b0}});
  assign ld_ready_o   = (r_count < CNT_W'(FIFO_DEPTH));
  // x0 loads complete the handshake but are dropped here
  assign w_push       = ld_valid_i && ld_ready_o && (ld_addr_i != {ADDR_WIDTH{1'b0}});

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a forced drain lasts exactly one cycle
  always_comb begin
    w_state_nxt = ST_NORMAL;
    case (r_state)
      ST_NORMAL: begin
        if (w_starve_nxt >= STV_W'(STARVE_LIMIT)) begin
          w_state_nxt = ST_FORCE_DRAIN;
        end else begin
          w_state_nxt = ST_NORMAL;
        end
      end
      ST_FORCE_DRAIN: w_state_nxt = ST_NORMAL;
      default:        w_state_nxt = ST_NORMAL;
    endcase
  end

  // FSM outputs: source selection for the write port and ALU handshake
  always_comb begin
    w_alu_ready = 1'b1;
    w_sel_alu   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        w_alu_ready = 1'b1;
        if (alu_valid_i && (alu_addr_i != {ADDR_WIDTH{1'b0}})) begin
          w_sel_alu = 1'b1;
        end else if (!w_fifo_empty) begin
          w_pop = 1'b1;
        end else begin
          w_sel_alu = 1'b0;
          w_pop     = 1'b0;
        end
      end
      ST_FORCE_DRAIN: begin
        w_alu_ready = 1'b0;
        if (!w_fifo_empty) begin
          w_pop = 1'b1;
        end else begin
          w_pop = 1'b0;
        end
      end
      default: begin
        w_alu_ready = 1'b1;
        w_sel_alu   = 1'b0;
        w_pop       = 1'b0;
      end
    endcase
  end

  assign alu_ready_o = w_alu_ready;

  // Starvation counter: counts cycles with a waiting head that is not popped
  always_comb begin
    if (w_pop) begin
      w_starve_nxt = {STV_W{1'b0}};
    end else if (!w_fifo_empty && (r_starve < STV_W'(STARVE_LIMIT))) begin
      w_starve_nxt = r_starve + STV_W'(1);
    end else begin
      w_starve_nxt = r_starve;
    end
  end

  // FIFO occupancy update; simultaneous push and pop leaves it unchanged
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO pointers, count and starvation counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr   <= {PTR_W{1'b0}};
      r_rptr   <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_starve <= {STV_W{1'b0}};
    end else begin
      r_wptr   <= w_push ? (r_wptr + PTR_W'(1)) : r_wptr;
      r_rptr   <= w_pop  ? (r_rptr + PTR_W'(1)) : r_rptr;
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // FIFO storage; validity is tracked by the count, so no reset is needed
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= ld_addr_i;
      r_fifo_data[r_wptr] <= ld_data_i;
    end
  end

  // Output stage: the write port is driven from a single register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= {ADDR_WIDTH{1'b0}};
      r_wr_data <= {DATA_WIDTH{1'b0}};
      r_out_ld  <= 1'b0;
    end else if (w_sel_alu) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= alu_addr_i;
      r_wr_data <= alu_data_i;
      r_out_ld  <= 1'b0;
    end else if (w_pop) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= r_fifo_addr[r_rptr];
      r_wr_data <= r_fifo_data[r_rptr];
      r_out_ld  <= 1'b1;
    end else begin
      r_wr_en   <= 1'b0;
      r_out_ld  <= 1'b0;
    end
  end

  assign wr_enable_o  = r_wr_en;
  assign wr_addr_o    = r_wr_addr;
  assign wr_data_o    = r_wr_data;
  assign fifo_count_o = r_count;

  // Pending-load mask: valid FIFO entries plus a load held in the output stage
  always_comb begin
    w_pending = {NREG{1'b0}};
    w_idx     = {PTR_W{1'b0}};
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_idx = r_rptr + PTR_W'(i);
      w_pending[r_fifo_addr[w_idx]] = w_pending[r_fifo_addr[w_idx]] | (CNT_W'(i) < r_count);
    end
    w_pending[r_wr_addr] = w_pending[r_wr_addr] | (r_wr_en & r_out_ld);
    w_pending[0] = 1'b0;
  end

  assign ld_pending_o = w_pending;

  // Bypass of the value the register file commits at the next edge
  always_comb begin
    byp_hit1_o = r_wr_en && (r_wr_addr == byp_addr1_i) && (byp_addr1_i != {ADDR_WIDTH{1'b0}});
    byp_hit2_o = r_wr_en && (r_wr_addr == byp_addr2_i) && (byp_addr2_i != {ADDR_WIDTH{1'b0}});
    if (byp_hit1_o) begin
      byp_data1_o = r_wr_data;
    end else begin
      byp_data1_o = {DATA_WIDTH{1'b0}};
    end
    if (byp_hit2_o) begin
      byp_data2_o = r_wr_data;
    end else begin
      byp_data2_o = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_regfile_wb_unit.sv
// Testbench for regfile_wb_unit: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the writeback rules.
module tb_regfile_wb_unit;

  logic        clk;
  logic        rst_i;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_addr_i;
  logic [31:0] alu_data_i;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [4:0]  ld_addr_i;
  logic [31:0] ld_data_i;
  logic        wr_enable_o;
  logic [4:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic [4:0]  byp_addr1_i;
  logic [4:0]  byp_addr2_i;
  logic        byp_hit1_o;
  logic        byp_hit2_o;
  logic [31:0] byp_data1_o;
  logic [31:0] byp_data2_o;
  logic [31:0] ld_pending_o;
  logic [2:0]  fifo_count_o;

  int n_tests;
  int n_fail;

  regfile_wb_unit #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
    .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
    .wr_enable_o(wr_enable_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .byp_addr1_i(byp_addr1_i), .byp_addr2_i(byp_addr2_i),
    .byp_hit1_o(byp_hit1_o), .byp_hit2_o(byp_hit2_o),
    .byp_data1_o(byp_data1_o), .byp_data2_o(byp_data2_o),
    .ld_pending_o(ld_pending_o), .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  ent_t        n_q[$];
  logic        m_wr_en, n_wr_en;
  logic [4:0]  m_wr_addr, n_wr_addr;
  logic [31:0] m_wr_data, n_wr_data;
  logic        m_out_ld, n_out_ld;
  int          m_starve, n_starve;
  logic        m_force, n_force;

  logic        exp_alu_ready, exp_ld_ready, exp_hit1, exp_hit2;
  logic [2:0]  exp_count;
  logic [31:0] exp_pending, exp_bd1, exp_bd2;

  task automatic model_reset();
    mq.delete();
    m_wr_en = 1'b0; m_wr_addr = 5'd0; m_wr_data = 32'd0; m_out_ld = 1'b0;
    m_starve = 0; m_force = 1'b0;
  endtask

  // Expected outputs for the current cycle and the model state after the edge
  task automatic model_eval();
    logic pop;
    logic sel_alu;
    ent_t head;
    exp_alu_ready = !m_force;
    exp_ld_ready  = (mq.size() < 4);
    exp_count     = 3'(mq.size());
    exp_pending   = 32'd0;
    foreach (mq[i]) exp_pending[mq[i].a] = 1'b1;
    if (m_wr_en && m_out_ld) exp_pending[m_wr_addr] = 1'b1;
    exp_pending[0] = 1'b0;
    exp_hit1 = m_wr_en && (m_wr_addr == byp_addr1_i) && (byp_addr1_i != 5'd0);
    exp_hit2 = m_wr_en && (m_wr_addr == byp_addr2_i) && (byp_addr2_i != 5'd0);
    exp_bd1  = exp_hit1 ? m_wr_data : 32'd0;
    exp_bd2  = exp_hit2 ? m_wr_data : 32'd0;

    pop = 1'b0; sel_alu = 1'b0;
    if (m_force) pop = (mq.size() > 0);
    else if (alu_valid_i && alu_addr_i != 5'd0) sel_alu = 1'b1;
    else if (mq.size() > 0) pop = 1'b1;

    n_q = mq;
    head = '0;
    if (pop) head = n_q.pop_front();
    if (pop) n_starve = 0;
    else if (mq.size() > 0) n_starve = m_starve + 1;
    else n_starve = m_starve;
    n_force = !m_force && (n_starve >= 8);
    if (ld_valid_i && mq.size() < 4 && ld_addr_i != 5'd0) n_q.push_back({ld_addr_i, ld_data_i});

    n_wr_addr = m_wr_addr; n_wr_data = m_wr_data;
    if (sel_alu) begin
      n_wr_en = 1'b1; n_wr_addr = alu_addr_i; n_wr_data = alu_data_i; n_out_ld = 1'b0;
    end else if (pop) begin
      n_wr_en = 1'b1; n_wr_addr = head.a; n_wr_data = head.d; n_out_ld = 1'b1;
    end else begin
      n_wr_en = 1'b0; n_out_ld = 1'b0;
    end
  endtask

  // Advance DUT and model by one clock; returns at the falling edge
  task automatic tick();
    mq = n_q;
    m_wr_en = n_wr_en; m_wr_addr = n_wr_addr; m_wr_data = n_wr_data; m_out_ld = n_out_ld;
    m_starve = n_starve; m_force = n_force;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid_i = 1'b0; alu_addr_i = 5'd0; alu_data_i = 32'd0;
    ld_valid_i = 1'b0; ld_addr_i = 5'd0; ld_data_i = 32'd0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b1; idle_inputs(); byp_addr1_i = 5'd3; byp_addr2_i = 5'd0;
    #3;
    n_tests++; if (wr_enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0b want 0", wr_enable_o); end
    n_tests++; if (wr_addr_o !== 5'd0 || wr_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_wr_bus: got %0d/%h want 0/0", wr_addr_o, wr_data_o); end
    n_tests++; if (fifo_count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count_o); end
    n_tests++; if (ld_pending_o !== 32'd0 || byp_hit1_o !== 1'b0) begin n_fail++; $display("FAIL reset_pend_byp: got %h/%0b want 0/0", ld_pending_o, byp_hit1_o); end
    @(posedge clk); @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    #1 model_eval();
    n_tests++; if (ld_ready_o !== 1'b1 || alu_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got ld=%0b alu=%0b want 1/1", ld_ready_o, alu_ready_o); end
    tick();
  endtask

  task automatic test_alu_single();
    idle_inputs(); byp_addr1_i = 5'd0; byp_addr2_i = 5'd6;
    alu_valid_i = 1'b1; alu_addr_i = 5'd5; alu_data_i = 32'hAAAA_AAAA;
    #1 model_eval();
    n_tests++; if (alu_ready_o !== 1'b1) begin n_fail++; $display("FAIL alu_ready: got %0b want 1", alu_ready_o); end
    tick();
    idle_inputs(); byp_addr1_i = 5'd5;
    #1 model_eval();
    n_tests++; if (wr_enable_o !== 1'b1 || wr_addr_o !== 5'd5 || wr_data_o !== 32'hAAAA_AAAA) begin
      n_fail++; $display("FAIL alu_write: got en=%0b a=%0d d=%h want 1/5/aaaaaaaa", wr_enable_o, wr_addr_o, wr_data_o); end
    n_tests++; if (byp_hit1_o !== 1'b1 || byp_data1_o !== 32'hAAAA_AAAA) begin
      n_fail++; $display("FAIL alu_bypass1: got %0b/%h want 1/aaaaaaaa", byp_hit1_o, byp_data1_o); end
    n_tests++; if (byp_hit2_o !== 1'b0 || byp_data2_o !== 32'd0) begin
      n_fail++; $display("FAIL alu_bypass2_miss: got %0b/%h want 0/0", byp_hit2_o, byp_data2_o); end
    tick();
    #1 model_eval();
    n_tests++; if (wr_enable_o !== 1'b0) begin n_fail++; $display("FAIL alu_wr_drop: got %0b want 0", wr_enable_o); end
    tick();
  endtask

  task automatic test_loads_in_order();
    int first_cyc;
    logic [4:0] seq[$];
    first_cyc = -1;
    byp_addr1_i = 5'd0; byp_addr2_i = 5'd0;
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      if (c < 4) begin
        ld_valid_i = 1'b1; ld_addr_i = 5'(c + 1); ld_data_i = 32'hA000_0001 + 32'(c);
      end
      #1 model_eval();
      if (c < 4) begin
        n_tests++; if (ld_ready_o !== 1'b1) begin n_fail++; $display("FAIL ld_accept_%0d: got %0b want 1", c, ld_ready_o); end
      end
      n_tests++; if (ld_pending_o !== exp_pending) begin n_fail++; $display("FAIL ld_pending_c%0d: got %h want %h", c, ld_pending_o, exp_pending); end
      n_tests++; if (wr_enable_o !== m_wr_en) begin n_fail++; $display("FAIL ld_wr_en_c%0d: got %0b want %0b", c, wr_enable_o, m_wr_en); end
      if (wr_enable_o) begin
        if (first_cyc < 0) first_cyc = c;
        seq.push_back(wr_addr_o);
        n_tests++; if (wr_data_o !== 32'hA000_0000 + 32'(wr_addr_o)) begin
          n_fail++; $display("FAIL ld_wr_data_c%0d: got %h want %h", c, wr_data_o, 32'hA000_0000 + 32'(wr_addr_o)); end
      end
      tick();
    end
    n_tests++; if (first_cyc != 2) begin n_fail++; $display("FAIL ld_latency: got %0d want 2", first_cyc); end
    n_tests++; if (seq.size() != 4) begin n_fail++; $display("FAIL ld_write_count: got %0d want 4", seq.size()); end
    else if (seq[0] !== 5'd1 || seq[1] !== 5'd2 || seq[2] !== 5'd3 || seq[3] !== 5'd4) begin
      n_fail++; $display("FAIL ld_order: got %0d %0d %0d %0d want 1 2 3 4", seq[0], seq[1], seq[2], seq[3]); end
  endtask

  task automatic test_starvation();
    int low_cnt;
    low_cnt = 0;
    byp_addr1_i = 5'd7; byp_addr2_i = 5'd1;
    for (int c = 0; c < 20; c++) begin
      idle_inputs();
      if (c < 12) begin alu_valid_i = 1'b1; alu_addr_i = 5'd7; alu_data_i = 32'hC000_0000 + 32'(c); end
      if (c < 5) begin ld_valid_i = 1'b1; ld_addr_i = 5'(c + 1); ld_data_i = 32'hB000_0001 + 32'(c); end
      #1 model_eval();
      if (c < 12 && alu_ready_o === 1'b0) low_cnt++;
      n_tests++; if (alu_ready_o !== exp_alu_ready) begin n_fail++; $display("FAIL starve_alu_ready_c%0d: got %0b want %0b", c, alu_ready_o, exp_alu_ready); end
      n_tests++; if (wr_enable_o !== m_wr_en || (m_wr_en && (wr_addr_o !== m_wr_addr || wr_data_o !== m_wr_data))) begin
        n_fail++; $display("FAIL starve_wr_c%0d: got %0b/%0d/%h want %0b/%0d/%h", c, wr_enable_o, wr_addr_o, wr_data_o, m_wr_en, m_wr_addr, m_wr_data); end
      n_tests++; if (byp_hit1_o !== exp_hit1 || byp_data2_o !== exp_bd2) begin
        n_fail++; $display("FAIL starve_byp_c%0d: got %0b/%h want %0b/%h", c, byp_hit1_o, byp_data2_o, exp_hit1, exp_bd2); end
      if (c == 4) begin
        n_tests++; if (ld_ready_o !== 1'b0 || fifo_count_o !== 3'd4) begin
          n_fail++; $display("FAIL starve_full: got ready=%0b count=%0d want 0/4", ld_ready_o, fifo_count_o); end
      end
      if (c == 9) begin
        n_tests++; if (alu_ready_o !== 1'b0) begin n_fail++; $display("FAIL starve_force: got %0b want 0", alu_ready_o); end
      end
      if (c == 10) begin
        n_tests++; if (wr_enable_o !== 1'b1 || wr_addr_o !== 5'd1 || wr_data_o !== 32'hB000_0001) begin
          n_fail++; $display("FAIL starve_drain_x1: got %0b/%0d/%h want 1/1/b0000001", wr_enable_o, wr_addr_o, wr_data_o); end
      end
      if (c == 11) begin
        n_tests++; if (wr_enable_o !== 1'b1 || wr_addr_o !== 5'd7 || wr_data_o !== 32'hC000_000A) begin
          n_fail++; $display("FAIL starve_alu_resume: got %0b/%0d/%h want 1/7/c000000a", wr_enable_o, wr_addr_o, wr_data_o); end
      end
      tick();
    end
    n_tests++; if (low_cnt != 1) begin n_fail++; $display("FAIL starve_low_cycles: got %0d want 1", low_cnt); end
  endtask

  task automatic test_x0();
    idle_inputs(); byp_addr1_i = 5'd0; byp_addr2_i = 5'd0;
    alu_valid_i = 1'b1; alu_addr_i = 5'd0; alu_data_i = 32'hDEAD_BEEF;
    ld_valid_i = 1'b1; ld_addr_i = 5'd0; ld_data_i = 32'h1234_5678;
    #1 model_eval();
    n_tests++; if (alu_ready_o !== 1'b1 || ld_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL x0_accept: got alu=%0b ld=%0b want 1/1", alu_ready_o, ld_ready_o); end
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      #1 model_eval();
      n_tests++; if (wr_enable_o !== 1'b0 || fifo_count_o !== 3'd0 || ld_pending_o[0] !== 1'b0) begin
        n_fail++; $display("FAIL x0_discard_c%0d: got en=%0b count=%0d p0=%0b want 0/0/0", c, wr_enable_o, fifo_count_o, ld_pending_o[0]); end
      tick();
    end
  endtask

  task automatic test_push_pop_wrap();
    ent_t pushed[$];
    ent_t got[$];
    byp_addr1_i = 5'd0; byp_addr2_i = 5'd0;
    for (int c = 0; c < 15; c++) begin
      idle_inputs();
      if (c < 2) begin alu_valid_i = 1'b1; alu_addr_i = 5'd30; alu_data_i = 32'h5555_0000 + 32'(c); end
      if (c < 10) begin
        ld_valid_i = 1'b1; ld_addr_i = 5'(c + 1); ld_data_i = $urandom;
        pushed.push_back({ld_addr_i, ld_data_i});
      end
      #1 model_eval();
      if (c >= 2 && c <= 9) begin
        n_tests++; if (fifo_count_o !== 3'd2) begin n_fail++; $display("FAIL wrap_count_c%0d: got %0d want 2", c, fifo_count_o); end
      end
      n_tests++; if (ld_pending_o !== exp_pending) begin n_fail++; $display("FAIL wrap_pending_c%0d: got %h want %h", c, ld_pending_o, exp_pending); end
      if (wr_enable_o === 1'b1 && wr_addr_o !== 5'd30) got.push_back({wr_addr_o, wr_data_o});
      tick();
    end
    n_tests++; if (got.size() != 10) begin n_fail++; $display("FAIL wrap_write_count: got %0d want 10", got.size()); end
    else begin
      for (int i = 0; i < 10; i++) begin
        n_tests++; if (got[i] !== pushed[i]) begin
          n_fail++; $display("FAIL wrap_order_%0d: got %0d/%h want %0d/%h", i, got[i].a, got[i].d, pushed[i].a, pushed[i].d); end
      end
    end
  endtask

  task automatic test_async_reset();
    byp_addr1_i = 5'd3; byp_addr2_i = 5'd0;
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      alu_valid_i = 1'b1; alu_addr_i = 5'd3; alu_data_i = 32'h7700_0000 + 32'(c);
      ld_valid_i = 1'b1; ld_addr_i = 5'(11 + c); ld_data_i = 32'h6600_0000 + 32'(c);
      #1 model_eval();
      tick();
    end
    idle_inputs();
    #1;
    n_tests++; if (fifo_count_o !== 3'd3 || wr_enable_o !== 1'b1) begin
      n_fail++; $display("FAIL arst_setup: got count=%0d en=%0b want 3/1", fifo_count_o, wr_enable_o); end
    rst_i = 1'b1;
    #1;
    n_tests++; if (wr_enable_o !== 1'b0 || wr_addr_o !== 5'd0 || wr_data_o !== 32'd0) begin
      n_fail++; $display("FAIL arst_wr: got %0b/%0d/%h want 0/0/0", wr_enable_o, wr_addr_o, wr_data_o); end
    n_tests++; if (fifo_count_o !== 3'd0 || ld_pending_o !== 32'd0) begin
      n_fail++; $display("FAIL arst_fifo: got %0d/%h want 0/0", fifo_count_o, ld_pending_o); end
    n_tests++; if (byp_hit1_o !== 1'b0 || byp_data1_o !== 32'd0) begin
      n_fail++; $display("FAIL arst_byp: got %0b/%h want 0/0", byp_hit1_o, byp_data1_o); end
    model_reset();
    @(posedge clk); @(negedge clk);
    rst_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 model_eval();
      n_tests++; if (fifo_count_o !== 3'd0 || ld_ready_o !== 1'b1 || wr_enable_o !== 1'b0 || ld_pending_o !== 32'd0) begin
        n_fail++; $display("FAIL arst_after_c%0d: got count=%0d rdy=%0b en=%0b pend=%h want 0/1/0/0", c, fifo_count_o, ld_ready_o, wr_enable_o, ld_pending_o); end
      tick();
    end
  endtask

  task automatic test_random();
    int alu_pct;
    for (int c = 0; c < 1200; c++) begin
      alu_pct = (c < 600) ? 50 : 92;
      idle_inputs();
      if (c < 1180) begin
        alu_valid_i = ($urandom_range(0, 99) < alu_pct);
        alu_addr_i  = 5'($urandom_range(0, 7));
        alu_data_i  = $urandom;
        ld_valid_i  = ($urandom_range(0, 99) < 55);
        ld_addr_i   = 5'($urandom_range(0, 7));
        ld_data_i   = $urandom;
      end
      byp_addr1_i = 5'($urandom_range(0, 7));
      byp_addr2_i = 5'($urandom_range(0, 7));
      #1 model_eval();
      n_tests++; if (wr_enable_o !== m_wr_en || (m_wr_en && (wr_addr_o !== m_wr_addr || wr_data_o !== m_wr_data))) begin
        n_fail++; $display("FAIL rnd_wr_c%0d: got %0b/%0d/%h want %0b/%0d/%h", c, wr_enable_o, wr_addr_o, wr_data_o, m_wr_en, m_wr_addr, m_wr_data); end
      n_tests++; if (alu_ready_o !== exp_alu_ready || ld_ready_o !== exp_ld_ready) begin
        n_fail++; $display("FAIL rnd_ready_c%0d: got %0b/%0b want %0b/%0b", c, alu_ready_o, ld_ready_o, exp_alu_ready, exp_ld_ready); end
      n_tests++; if (fifo_count_o !== exp_count) begin
        n_fail++; $display("FAIL rnd_count_c%0d: got %0d want %0d", c, fifo_count_o, exp_count); end
      n_tests++; if (ld_pending_o !== exp_pending) begin
        n_fail++; $display("FAIL rnd_pending_c%0d: got %h want %h", c, ld_pending_o, exp_pending); end
      n_tests++; if (byp_hit1_o !== exp_hit1 || byp_data1_o !== exp_bd1 || byp_hit2_o !== exp_hit2 || byp_data2_o !== exp_bd2) begin
        n_fail++; $display("FAIL rnd_bypass_c%0d: got %0b/%h %0b/%h want %0b/%h %0b/%h", c, byp_hit1_o, byp_data1_o, byp_hit2_o, byp_data2_o, exp_hit1, exp_bd1, exp_hit2, exp_bd2); end
      tick();
    end
  endtask

  initial begin
    clk = 1'b0;
    n_tests = 0;
    n_fail = 0;
    rst_i = 1'b1;
    idle_inputs();
    byp_addr1_i = 5'd0;
    byp_addr2_i = 5'd0;
    model_reset();
    test_reset();
    test_alu_single();
    test_loads_in_order();
    test_starvation();
    test_x0();
    test_push_pop_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
